usd_range_ctrl: RTL

- Drives the `trigger` input of the ultrasonic sensor interface periodically and samples its 16-bit echo time in µs (`sensor_response`).
- Rejects timeouts, averages the last 4 valid echoes, converts the average to centimetres and flags obstacles with hysteresis.
- Feeds the downstream PWM/motor control logic with `distance_cm`, `obstacle` and a one-cycle `sample_valid` strobe.

---
 rtl/usd_range_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/usd_range_ctrl.sv
// Ultrasonic range controller: periodic trigger, echo capture,
// 4-sample moving average, cm conversion and obstacle hysteresis.
module usd_range_ctrl #(
  parameter int TRIG_HIGH_CYCLES = 1000000,
  parameter int SETTLE_CYCLES    = 4,
  parameter int PERIOD_CYCLES    = 3000000,
  parameter int TIMEOUT_US       = 10000,
  parameter int NEAR_CM          = 30,
  parameter int FAR_CM           = 40
) (
  input  logic        clk_50mhz,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] sensor_response,
  output logic        measure_trigger,
  output logic [15:0] raw_us,
  output logic [15:0] distance_cm,
  output logic        sample_valid,
  output logic        no_echo,
  output logic        obstacle
);

  localparam int TMAX =
    (TRIG_HIGH_CYCLES > SETTLE_CYCLES) ?
    TRIG_HIGH_CYCLES : SETTLE_CYCLES;
  localparam int TCW = $clog2(TMAX + 1);
  localparam int PCW = $clog2(PERIOD_CYCLES + 1);

  localparam logic [TCW-1:0] T_LAST =
    TCW'(TRIG_HIGH_CYCLES - 1);
  localparam logic [TCW-1:0] S_LAST =
    TCW'(SETTLE_CYCLES - 1);
  localparam logic [PCW-1:0] P_LAST =
    PCW'(PERIOD_CYCLES - 1);
  localparam logic [15:0] TO_US = 16'(TIMEOUT_US);
  localparam logic [15:0] NEAR  = 16'(NEAR_CM);
  localparam logic [15:0] FAR   = 16'(FAR_CM);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    SETTLE,
    CAPTURE,
    CONVERT,
    WAIT
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [PCW-1:0] pcnt;
  logic [PCW-1:0] pcnt_nx;
  logic [TCW-1:0] tcnt;
  logic [TCW-1:0] tcnt_nx;

  logic [15:0] hist [4];
  logic [17:0] sum;
  logic        empty;

  logic        is_cap;
  logic        is_cnv;
  logic        resp_to;
  logic        raw_to;
  logic [15:0] avg;
  logic [26:0] prod;
  logic [15:0] dist_nx;
  logic        obst_nx;

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pcnt  <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      pcnt  <= pcnt_nx;
      tcnt  <= tcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pcnt_nx  = pcnt + 1'b1;
    tcnt_nx  = tcnt + 1'b1;
    unique case (state)
      IDLE: begin
        pcnt_nx = '0;
        tcnt_nx = '0;
        if (enable) state_nx = TRIG;
      end
      TRIG: begin
        if (tcnt == T_LAST) begin
          state_nx = SETTLE;
          tcnt_nx  = '0;
        end
      end
      SETTLE: begin
        if (tcnt == S_LAST) begin
          state_nx = CAPTURE;
          tcnt_nx  = '0;
        end
      end
      CAPTURE: state_nx = CONVERT;
      CONVERT: state_nx = WAIT;
      WAIT: begin
        if (pcnt == P_LAST) begin
          state_nx = enable ? TRIG : IDLE;
          pcnt_nx  = '0;
          tcnt_nx  = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Dropping enable aborts any measurement in flight.
    if (state != IDLE && !enable) begin
      state_nx = IDLE;
      pcnt_nx  = '0;
      tcnt_nx  = '0;
    end
  end

  // Decoded from the state flop, so reset clears it asynchronously.
  assign measure_trigger = (state == TRIG);

  assign is_cap  = (state == CAPTURE) && enable;
  assign is_cnv  = (state == CONVERT) && enable;
  assign resp_to = (sensor_response >= TO_US);
  assign raw_to  = (raw_us >= TO_US);

  // cm = us / 58 approximated as us * 1130 / 65536.
  assign avg     = 16'(sum >> 2);
  assign prod    = 27'(avg) * 27'd1130;
  assign dist_nx = 16'(prod >> 16);

  always_comb begin
    obst_nx = obstacle;
    if (dist_nx < NEAR)
      obst_nx = 1'b1;
    else if (dist_nx >= FAR)
      obst_nx = 1'b0;
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      raw_us       <= '0;
      distance_cm  <= '0;
      sample_valid <= 1'b0;
      no_echo      <= 1'b0;
      obstacle     <= 1'b0;
      sum          <= '0;
      empty        <= 1'b1;
      for (int i = 0; i < 4; i++)
        hist[i] <= '0;
    end else begin
      sample_valid <= is_cnv;
      if (is_cap) begin
        raw_us <= sensor_response;
        if (resp_to) begin
          empty <= 1'b1;
        end else if (empty) begin
          empty <= 1'b0;
          sum   <= {sensor_response, 2'b00};
          for (int i = 0; i < 4; i++)
            hist[i] <= sensor_response;
        end else begin
          sum <= sum
               - {2'b00, hist[3]}
               + {2'b00, sensor_response};
          hist[0] <= sensor_response;
          hist[1] <= hist[0];
          hist[2] <= hist[1];
          hist[3] <= hist[2];
        end
      end
      if (is_cnv) begin
        if (raw_to) begin
          no_echo  <= 1'b1;
          obstacle <= 1'b0;
        end else begin
          no_echo     <= 1'b0;
          distance_cm <= dist_nx;
          obstacle    <= obst_nx;
        end
      end
    end
  end

endmodule
